// File: rtl/m_skid_buf.sv
// m_skid_buf: two-entry registered valid/ready skid buffer.
// All outputs (out_valid, out_data, in_ready) come straight from flops, so
// there is no combinational path from out_ready back to in_ready.
//
// Optional build macro: M_SKID_XCHECK_EN
//   When defined, a simulation-only monitor watches in_valid, out_ready and
//   flush for X/Z and for upstream withdrawing in_valid while stalled. It
//   counts problems in err_cnt. When undefined, no checker is built.
//
// state | meaning
// EMPTY | nothing held; out_valid=0, in_ready=1
// BUSY  | one word in main; out_valid=1, in_ready=1
// FULL  | main and skid both hold words; out_valid=1, in_ready=0

module m_skid_buf #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Handshake FSM; main register is out_data itself, flags are registered.
  // in_ready resets low so nothing is taken until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= RESET_VAL;
      skid      <= RESET_VAL;
    end else if (flush) begin
      // Flush wins over everything; a word offered this cycle is dropped.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            // Consumer stalled: park the new word and stop accepting.
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_data <= skid;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef M_SKID_XCHECK_EN
`ifndef SYNTHESIS
  integer err_cnt;
  logic   prev_in_valid;
  logic   prev_in_ready;
  logic   prev_flush;

  // Input sanity monitor: unknown controls, and a stalled word being
  // withdrawn before it was taken (a flush the cycle before excuses it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt       <= 0;
      prev_in_valid <= 1'b0;
      prev_in_ready <= 1'b0;
      prev_flush    <= 1'b0;
    end else begin
      prev_in_valid <= in_valid;
      prev_in_ready <= in_ready;
      prev_flush    <= flush;
      if ($isunknown(in_valid)) begin
        $display("ERROR m_skid_buf @%0t: in_valid is X/Z", $time);
        err_cnt <= err_cnt + 1;
      end else if ($isunknown(out_ready)) begin
        $display("ERROR m_skid_buf @%0t: out_ready is X/Z", $time);
        err_cnt <= err_cnt + 1;
      end else if ($isunknown(flush)) begin
        $display("ERROR m_skid_buf @%0t: flush is X/Z", $time);
        err_cnt <= err_cnt + 1;
      end else if (prev_in_valid === 1'b1 && in_valid === 1'b0 &&
                   prev_in_ready === 1'b0 && prev_flush !== 1'b1) begin
        $display("ERROR m_skid_buf @%0t: in_valid dropped while in_ready=0", $time);
        err_cnt <= err_cnt + 1;
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_m_skid_buf.sv
// tb_m_skid_buf: scoreboard bench for m_skid_buf (WIDTH=8, RESET_VAL=8'hA5).
// Inputs change on the falling edge; handshakes are evaluated just after,
// before the rising edge that acts on them.

module tb_m_skid_buf;

  localparam int unsigned WIDTH = 8;
  localparam logic [7:0]  RVAL  = 8'hA5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  logic [7:0] sb[$];
  int n_cmp;
  int n_bad;

  m_skid_buf #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, score the handshakes, let the edge happen.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl, output logic acc);
    logic [7:0] exp;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = 1'b0;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        check_val("out_data", {24'd0, out_data}, {24'd0, exp});
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1 && !fl) begin
      sb.push_back(id);
      acc = 1'b1;
    end
    if (fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic acc;
    int k;
    k = 0;
    while (out_valid === 1'b1 && k < 20) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      k++;
    end
    check_val({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    logic pending;
    int   k;
    n_cmp = 0;
    n_bad = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_data", {24'd0, out_data}, {24'd0, RVAL});
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef M_SKID_XCHECK_EN
    step(1'bx, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_val("xcheck_err_cnt", dut.err_cnt, 32'd1);
`endif

    // Single word, one-cycle latency
    step(1'b1, 8'h3C, 1'b1, 1'b0, acc);
    check_val("single_valid", {31'd0, out_valid}, 32'd1);
    check_val("single_data", {24'd0, out_data}, 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_val("single_empty", {31'd0, out_valid}, 32'd0);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      check_val("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step(1'b1, 8'(i), 1'b1, 1'b0, acc);
    end
    check_val("stream_in_ready_end", {31'd0, in_ready}, 32'd1);
    drain("stream");

    // Back-pressure: third word held off until space frees
    step(1'b1, 8'h11, 1'b0, 1'b0, acc);
    check_val("bp_in_ready_1", {31'd0, in_ready}, 32'd1);
    step(1'b1, 8'h22, 1'b0, 1'b0, acc);
    check_val("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h33, 1'b0, 1'b0, acc);
      check_val("bp_held_off", {31'd0, acc}, 32'd0);
      check_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_hold_data", {24'd0, out_data}, 32'h11);
    end
    pending = 1'b1;
    k = 0;
    while ((pending || out_valid === 1'b1) && k < 20) begin
      step(pending, 8'h33, 1'b1, 1'b0, acc);
      if (acc) pending = 1'b0;
      k++;
    end
    check_val("bp_33_taken", {31'd0, pending}, 32'd0);
    drain("bp");

    // Flush while FULL drops both held words and the concurrent offer
    step(1'b1, 8'h44, 1'b0, 1'b0, acc);
    step(1'b1, 8'h55, 1'b0, 1'b0, acc);
    check_val("fl_full", {31'd0, in_ready}, 32'd0);
    step(1'b1, 8'h66, 1'b0, 1'b1, acc);
    check_val("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("fl_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check_val("fl_no_66", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset while FULL
    step(1'b1, 8'h88, 1'b0, 1'b0, acc);
    step(1'b1, 8'h99, 1'b0, 1'b0, acc);
    check_val("ar_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("ar_out_data", {24'd0, out_data}, {24'd0, RVAL});
    check_val("ar_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    check_val("ar_77_valid", {31'd0, out_valid}, 32'd1);
    check_val("ar_77_data", {24'd0, out_data}, 32'h77);
    drain("ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
